// File: rtl/dag_addr_gen.sv
// Data address generator.
// Holds NSET circular-buffer register sets (I index, M modify, L length, B base).
// Produces data-memory addresses with pre-/post-modify and modulo wrap.
// Register read-back is registered onto dg_bc_dt for the bus-connect mux.
module dag_addr_gen #(
   parameter int DW   = 16,
   parameter int NSET = 4
) (
   input  logic                     clk_dcd,
   input  logic                     rst,
   input  logic                     ps_dg_wrt_en,
   input  logic [1:0]               ps_dg_wrt_typ,
   input  logic [$clog2(NSET)-1:0]  ps_dg_wrt_idx,
   input  logic [DW-1:0]            bc_dt,
   input  logic                     ps_dg_rd_en,
   input  logic [1:0]               ps_dg_rd_typ,
   input  logic [$clog2(NSET)-1:0]  ps_dg_rd_idx,
   output logic [DW-1:0]            dg_bc_dt,
   input  logic                     ps_dg_en,
   input  logic [$clog2(NSET)-1:0]  ps_dg_iidx,
   input  logic [$clog2(NSET)-1:0]  ps_dg_midx,
   input  logic                     ps_dg_imm_sel,
   input  logic [DW-1:0]            ps_dg_immod,
   input  logic                     ps_dg_pre,
   output logic [DW-1:0]            dg_dm_add,
   output logic                     dg_dm_add_vld
);

   // Register encoding shared by the write and read ports.
   localparam logic [1:0] TYP_I = 2'b00;
   localparam logic [1:0] TYP_M = 2'b01;
   localparam logic [1:0] TYP_L = 2'b10;

   // Register file state and next state.
   logic [DW-1:0] i_q [NSET];
   logic [DW-1:0] m_q [NSET];
   logic [DW-1:0] l_q [NSET];
   logic [DW-1:0] b_q [NSET];
   logic [DW-1:0] i_d [NSET];
   logic [DW-1:0] m_d [NSET];
   logic [DW-1:0] l_d [NSET];
   logic [DW-1:0] b_d [NSET];

   // Output registers.
   logic [DW-1:0] rd_dt_q, rd_dt_d;
   logic [DW-1:0] add_q, add_d;
   logic          vld_q, vld_d;

   // Address datapath.
   logic [DW-1:0] cur_i_s;
   logic [DW-1:0] cur_l_s;
   logic [DW-1:0] cur_b_s;
   logic [DW-1:0] mod_s;
   logic [DW:0]   sum_s;
   logic [DW:0]   lim_s;
   logic [DW-1:0] res_s;
   logic [DW-1:0] rd_val_s;

   // Modifier select, raw sum in DW+1 bits and single modulo wrap against [B, B+L).
   always_comb begin
      cur_i_s = i_q[ps_dg_iidx];
      cur_l_s = l_q[ps_dg_iidx];
      cur_b_s = b_q[ps_dg_iidx];
      if (ps_dg_imm_sel) begin
         mod_s = ps_dg_immod;
      end else begin
         mod_s = m_q[ps_dg_midx];
      end
      // The modifier is sign-extended, the index is unsigned.
      sum_s = {1'b0, cur_i_s} + {mod_s[DW-1], mod_s};
      lim_s = {1'b0, cur_b_s} + {1'b0, cur_l_s};
      res_s = sum_s[DW-1:0];
      if (cur_l_s != {DW{1'b0}}) begin
         if (!mod_s[DW-1]) begin
            if (sum_s >= lim_s) begin
               res_s = sum_s[DW-1:0] - cur_l_s;
            end else begin
               res_s = sum_s[DW-1:0];
            end
         end else begin
            if (sum_s < {1'b0, cur_b_s}) begin
               res_s = sum_s[DW-1:0] + cur_l_s;
            end else begin
               res_s = sum_s[DW-1:0];
            end
         end
      end else begin
         res_s = sum_s[DW-1:0];
      end
   end

   // Read-back mux on pre-edge register values (no write bypass).
   always_comb begin
      case (ps_dg_rd_typ)
         TYP_I:   rd_val_s = i_q[ps_dg_rd_idx];
         TYP_M:   rd_val_s = m_q[ps_dg_rd_idx];
         TYP_L:   rd_val_s = l_q[ps_dg_rd_idx];
         default: rd_val_s = b_q[ps_dg_rd_idx];
      endcase
   end

   // Next-state for registers: post-modify update first, explicit write applied last so it wins.
   always_comb begin
      for (int k = 0; k < NSET; k++) begin
         i_d[k] = i_q[k];
         m_d[k] = m_q[k];
         l_d[k] = l_q[k];
         b_d[k] = b_q[k];
      end
      if (ps_dg_en && !ps_dg_pre) begin
         i_d[ps_dg_iidx] = res_s;
      end else begin
         i_d[ps_dg_iidx] = i_q[ps_dg_iidx];
      end
      if (ps_dg_wrt_en) begin
         case (ps_dg_wrt_typ)
            TYP_I:   i_d[ps_dg_wrt_idx] = bc_dt;
            TYP_M:   m_d[ps_dg_wrt_idx] = bc_dt;
            TYP_L:   l_d[ps_dg_wrt_idx] = bc_dt;
            default: begin
               // Writing a base restarts the buffer at that base.
               b_d[ps_dg_wrt_idx] = bc_dt;
               i_d[ps_dg_wrt_idx] = bc_dt;
            end
         endcase
      end else begin
         m_d[ps_dg_wrt_idx] = m_q[ps_dg_wrt_idx];
      end
   end

   // Next-state for the registered outputs; address and read data hold when idle.
   always_comb begin
      vld_d = ps_dg_en;
      if (ps_dg_en) begin
         if (ps_dg_pre) begin
            add_d = res_s;
         end else begin
            add_d = cur_i_s;
         end
      end else begin
         add_d = add_q;
      end
      if (ps_dg_rd_en) begin
         rd_dt_d = rd_val_s;
      end else begin
         rd_dt_d = rd_dt_q;
      end
   end

   // State update with asynchronous clear of every register and output.
   always_ff @(posedge clk_dcd or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NSET; k++) begin
            i_q[k] <= {DW{1'b0}};
            m_q[k] <= {DW{1'b0}};
            l_q[k] <= {DW{1'b0}};
            b_q[k] <= {DW{1'b0}};
         end
         rd_dt_q <= {DW{1'b0}};
         add_q   <= {DW{1'b0}};
         vld_q   <= 1'b0;
      end else begin
         for (int k = 0; k < NSET; k++) begin
            i_q[k] <= i_d[k];
            m_q[k] <= m_d[k];
            l_q[k] <= l_d[k];
            b_q[k] <= b_d[k];
         end
         rd_dt_q <= rd_dt_d;
         add_q   <= add_d;
         vld_q   <= vld_d;
      end
   end

   assign dg_bc_dt      = rd_dt_q;
   assign dg_dm_add     = add_q;
   assign dg_dm_add_vld = vld_q;

endmodule

// File: tb/tb_dag_addr_gen.sv
// Scoreboard bench for dag_addr_gen: stimulus pushes expected read data and
// addresses into queues, a monitor pops and compares when the DUT presents them.
module tb_dag_addr_gen;

   logic        clk_dcd = 1'b0;
   logic        rst = 1'b0;
   logic        ps_dg_wrt_en = 1'b0;
   logic [1:0]  ps_dg_wrt_typ = 2'b00;
   logic [1:0]  ps_dg_wrt_idx = 2'b00;
   logic [15:0] bc_dt = 16'h0000;
   logic        ps_dg_rd_en = 1'b0;
   logic [1:0]  ps_dg_rd_typ = 2'b00;
   logic [1:0]  ps_dg_rd_idx = 2'b00;
   logic [15:0] dg_bc_dt;
   logic        ps_dg_en = 1'b0;
   logic [1:0]  ps_dg_iidx = 2'b00;
   logic [1:0]  ps_dg_midx = 2'b00;
   logic        ps_dg_imm_sel = 1'b0;
   logic [15:0] ps_dg_immod = 16'h0000;
   logic        ps_dg_pre = 1'b0;
   logic [15:0] dg_dm_add;
   logic        dg_dm_add_vld;

   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0] add_exp_q[$];
   logic [15:0] rd_exp_q[$];
   logic        rd_pend = 1'b0;

   dag_addr_gen #(.DW(16), .NSET(4)) dut (
      .clk_dcd       (clk_dcd),
      .rst           (rst),
      .ps_dg_wrt_en  (ps_dg_wrt_en),
      .ps_dg_wrt_typ (ps_dg_wrt_typ),
      .ps_dg_wrt_idx (ps_dg_wrt_idx),
      .bc_dt         (bc_dt),
      .ps_dg_rd_en   (ps_dg_rd_en),
      .ps_dg_rd_typ  (ps_dg_rd_typ),
      .ps_dg_rd_idx  (ps_dg_rd_idx),
      .dg_bc_dt      (dg_bc_dt),
      .ps_dg_en      (ps_dg_en),
      .ps_dg_iidx    (ps_dg_iidx),
      .ps_dg_midx    (ps_dg_midx),
      .ps_dg_imm_sel (ps_dg_imm_sel),
      .ps_dg_immod   (ps_dg_immod),
      .ps_dg_pre     (ps_dg_pre),
      .dg_dm_add     (dg_dm_add),
      .dg_dm_add_vld (dg_dm_add_vld)
   );

   always #5 clk_dcd = ~clk_dcd;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
      end
   endtask

   // Register file encodings
   localparam logic [1:0] TI = 2'b00;
   localparam logic [1:0] TM = 2'b01;
   localparam logic [1:0] TL = 2'b10;
   localparam logic [1:0] TB = 2'b11;

   // Remember whether a read strobe was sampled at this edge.
   always @(posedge clk_dcd) begin
      rd_pend = ps_dg_rd_en & ~rst;
   end

   // Monitor: compare presented outputs against the scoreboard queues.
   always @(negedge clk_dcd) begin
      if (rd_pend) begin
         if (rd_exp_q.size() == 0) begin
            chk("read_unexpected", dg_bc_dt, 16'hxxxx);
         end else begin
            chk("read_data", dg_bc_dt, rd_exp_q.pop_front());
         end
      end
      if (dg_dm_add_vld === 1'b1) begin
         if (add_exp_q.size() == 0) begin
            chk("addr_unexpected", dg_dm_add, 16'hxxxx);
         end else begin
            chk("addr", dg_dm_add, add_exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk_dcd);
      #1;
      ps_dg_wrt_en = 1'b0;
      ps_dg_rd_en  = 1'b0;
      ps_dg_en     = 1'b0;
   endtask

   task automatic set_wr(input logic [1:0] typ, input logic [1:0] idx, input logic [15:0] d);
      ps_dg_wrt_en  = 1'b1;
      ps_dg_wrt_typ = typ;
      ps_dg_wrt_idx = idx;
      bc_dt         = d;
   endtask

   task automatic set_rd(input logic [1:0] typ, input logic [1:0] idx, input logic [15:0] exp);
      ps_dg_rd_en  = 1'b1;
      ps_dg_rd_typ = typ;
      ps_dg_rd_idx = idx;
      rd_exp_q.push_back(exp);
   endtask

   task automatic set_gen(input logic [1:0] iidx, input logic [1:0] midx, input logic imm,
                          input logic [15:0] immod, input logic pre, input logic [15:0] exp);
      ps_dg_en      = 1'b1;
      ps_dg_iidx    = iidx;
      ps_dg_midx    = midx;
      ps_dg_imm_sel = imm;
      ps_dg_immod   = immod;
      ps_dg_pre     = pre;
      add_exp_q.push_back(exp);
   endtask

   task automatic wr(input logic [1:0] typ, input logic [1:0] idx, input logic [15:0] d);
      set_wr(typ, idx, d);
      step();
   endtask

   task automatic rd(input logic [1:0] typ, input logic [1:0] idx, input logic [15:0] exp);
      set_rd(typ, idx, exp);
      step();
   endtask

   task automatic gen(input logic [1:0] iidx, input logic [1:0] midx, input logic imm,
                      input logic [15:0] immod, input logic pre, input logic [15:0] exp);
      set_gen(iidx, midx, imm, immod, pre, exp);
      step();
   endtask

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [15:0] circ_exp [5];

   initial begin
      circ_exp[0] = 16'h0100;
      circ_exp[1] = 16'h0101;
      circ_exp[2] = 16'h0102;
      circ_exp[3] = 16'h0103;
      circ_exp[4] = 16'h0100;

      // Asynchronous reset between edges
      #2 rst = 1'b1;
      #1;
      chk("rst_bc_dt", dg_bc_dt, 16'h0000);
      chk("rst_dm_add", dg_dm_add, 16'h0000);
      chk("rst_vld", {15'd0, dg_dm_add_vld}, 16'h0000);
      repeat (2) @(posedge clk_dcd);
      #1 rst = 1'b0;

      // All registers read back zero
      for (int k = 0; k < 4; k++) begin
         rd(TI, k[1:0], 16'h0000);
         rd(TM, k[1:0], 16'h0000);
         rd(TL, k[1:0], 16'h0000);
         rd(TB, k[1:0], 16'h0000);
      end

      // Base write restarts I; M write read back one cycle later
      wr(TB, 2'd0, 16'h0100);
      rd(TI, 2'd0, 16'h0100);
      rd(TB, 2'd0, 16'h0100);
      wr(TM, 2'd1, 16'h0003);
      rd(TM, 2'd1, 16'h0003);

      // Circular post-modify, length 4, step 1
      wr(TL, 2'd0, 16'h0004);
      wr(TM, 2'd0, 16'h0001);
      for (int k = 0; k < 5; k++) begin
         gen(2'd0, 2'd0, 1'b0, 16'h0000, 1'b0, circ_exp[k]);
      end
      step();
      chk("vld_drop", {15'd0, dg_dm_add_vld}, 16'h0000);
      chk("addr_hold", dg_dm_add, 16'h0100);
      rd(TI, 2'd0, 16'h0101);

      // Negative wrap with pre-modify: I stays
      wr(TB, 2'd2, 16'h0200);
      wr(TL, 2'd2, 16'h0008);
      wr(TI, 2'd2, 16'h0201);
      gen(2'd2, 2'd0, 1'b1, 16'hFFFD, 1'b1, 16'h0206);
      rd(TI, 2'd2, 16'h0201);
      // Positive wrap with pre-modify at exactly B+L
      gen(2'd2, 2'd0, 1'b1, 16'h0007, 1'b1, 16'h0200);
      // Just below B+L: no wrap
      gen(2'd2, 2'd0, 1'b1, 16'h0006, 1'b1, 16'h0207);

      // Linear overflow with L=0
      wr(TI, 2'd3, 16'hFFFE);
      wr(TM, 2'd3, 16'h0004);
      gen(2'd3, 2'd3, 1'b0, 16'h0000, 1'b0, 16'hFFFE);
      rd(TI, 2'd3, 16'h0002);

      // Collision: explicit write to I0 beats post-modify update
      set_gen(2'd0, 2'd0, 1'b0, 16'h0000, 1'b0, 16'h0101);
      set_wr(TI, 2'd0, 16'h0055);
      step();
      rd(TI, 2'd0, 16'h0055);

      // Write M0 while generating with M0 and reading M0: old M used and read
      set_gen(2'd0, 2'd0, 1'b0, 16'h0000, 1'b0, 16'h0055);
      set_wr(TM, 2'd0, 16'h0002);
      set_rd(TM, 2'd0, 16'h0001);
      step();
      gen(2'd0, 2'd0, 1'b0, 16'h0000, 1'b0, 16'h0056);
      rd(TI, 2'd0, 16'h0058);
      rd(TM, 2'd0, 16'h0002);

      // Mid-sequence reset after a generation pulse has been checked
      gen(2'd3, 2'd3, 1'b0, 16'h0000, 1'b0, 16'h0002);
      #6 rst = 1'b1;
      #1;
      chk("midrst_bc_dt", dg_bc_dt, 16'h0000);
      chk("midrst_dm_add", dg_dm_add, 16'h0000);
      chk("midrst_vld", {15'd0, dg_dm_add_vld}, 16'h0000);
      @(posedge clk_dcd);
      #1 rst = 1'b0;
      rd(TI, 2'd0, 16'h0000);
      rd(TL, 2'd0, 16'h0000);
      rd(TB, 2'd0, 16'h0000);
      rd(TM, 2'd3, 16'h0000);
      // First generation after release: I=0, L=0
      gen(2'd0, 2'd0, 1'b1, 16'h0005, 1'b0, 16'h0000);
      rd(TI, 2'd0, 16'h0005);

      repeat (3) step();
      chk("addr_queue_drained", add_exp_q.size() > 0 ? 16'h0001 : 16'h0000, 16'h0000);
      chk("read_queue_drained", rd_exp_q.size() > 0 ? 16'h0001 : 16'h0000, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dag_addr_gen.md
Name: dag_addr_gen

Overview:
- Data address generator. Holds circular-buffer register sets (I index, M modify, L length, B base).
- Produces data-memory addresses with pre-/post-modify and modulo wrap.
- Sits directly upstream of the bus-connect mux: its register read-back drives dg_bc_dt.
- Register writes arrive on bc_dt, the bus-connect output. Control comes from the program sequencer.

Parameters:
DW, 16, data/address width
NSET, 4, number of I/M/L/B register sets (index width = log2(NSET) = 2 at default)

Ports:
clk_dcd  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
ps_dg_wrt_en  input  1  register write strobe
ps_dg_wrt_typ  input  2  write target: 00=I, 01=M, 10=L, 11=B
ps_dg_wrt_idx  input  2  register set for write
bc_dt  input  DW  write data from bus connect
ps_dg_rd_en  input  1  register read strobe
ps_dg_rd_typ  input  2  read target, same encoding as write
ps_dg_rd_idx  input  2  register set for read
dg_bc_dt  output  DW  registered read data to bus connect
ps_dg_en  input  1  address-generation request
ps_dg_iidx  input  2  I/L/B set used for generation
ps_dg_midx  input  2  M register used when ps_dg_imm_sel=0
ps_dg_imm_sel  input  1  1=use ps_dg_immod as modifier
ps_dg_immod  input  DW  signed immediate modifier
ps_dg_pre  input  1  1=pre-modify (address = I+M, I unchanged); 0=post-modify (address = I, then I updated)
dg_dm_add  output  DW  registered data-memory address
dg_dm_add_vld  output  1  address valid, one-cycle pulse

Behaviour:
- Reset (async, rst=1): all I, M, L, B = 0; dg_bc_dt = 0; dg_dm_add = 0; dg_dm_add_vld = 0. Deassertion is sampled on clk_dcd.
- Modifier mod = ps_dg_imm_sel ? ps_dg_immod : M[midx]. Treated as signed two's-complement DW bits.
- Raw sum s = I + mod, computed in DW+1 bits.
- Wrap when L[iidx] != 0:
  - mod >= 0 and s >= B+L: result = s - L.
  - mod < 0 and s < B: result = s + L.
  - otherwise result = s.
- Compares use DW+1 unsigned bits. Result is truncated to DW. At most one wrap is applied; |mod| <= L is the caller's responsibility.
- L = 0 gives linear addressing: result = s truncated to DW.
- Generation (ps_dg_en=1), latency 1 cycle:
  - next edge: dg_dm_add_vld = 1.
  - post-modify: dg_dm_add = I; I[iidx] <= result.
  - pre-modify: dg_dm_add = result; I unchanged.
- ps_dg_en=0: dg_dm_add_vld = 0 next cycle; dg_dm_add holds its last value.
- Register write (ps_dg_wrt_en=1): target written with bc_dt on the next edge.
  - Writing B[k] also loads I[k] with bc_dt (buffer restart).
- Read (ps_dg_rd_en=1): dg_bc_dt <= selected register on the next edge.
  - Read returns the pre-edge value; no same-cycle write bypass.
  - ps_dg_rd_en=0: dg_bc_dt holds its last value.
- Collision, write and post-modify update target the same I[k] in one cycle: the explicit write wins. The generated address still uses the old I.
- Generation in the same cycle as a write to M/L/B of the set in use: generation uses the old values.
- Read, write and generation may all occur in one cycle; they are independent except for the collision rules above.
- rst asserted mid-sequence: everything clears immediately. The first generation after release uses I=0 and L=0.

Test Plan:
- Reset: assert rst asynchronously between edges -> dg_bc_dt=0, dg_dm_add=0, dg_dm_add_vld=0 immediately; all registers read back 0.
- Write/read-back: write B0=0x0100 -> reading I0 gives 0x0100. Write M1=0x0003, read M1 -> dg_bc_dt=0x0003 exactly one cycle after the read strobe.
- Circular post-modify: B0=0x0100, L0=4, M0=1. Four consecutive generations -> addresses 0x100, 0x101, 0x102, 0x103; the fifth gives 0x100 (wrap).
- Negative wrap with pre-modify: B2=0x0200, L2=8, I2=0x0201, immediate -3, pre=1 -> dg_dm_add=0x0206; I2 stays 0x0201.
- Linear overflow: L3=0, I3=0xFFFE, M3=4, post -> address 0xFFFE; I3 becomes 0x0002.
- Collision: post-modify on I0 while writing I0=0x0055 in the same cycle -> address uses the old I0; I0=0x0055 afterwards.
